// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared FSM state encodings and id type for the tri-state bus arbiter.
// Purely declarative; no logic, latency or flow control lives here.
package tristate_bus_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   localparam int IdWidth = 3;
   typedef logic [IdWidth-1:0] port_id_t;

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin search: first requester strictly after i_last_id, wrapping.
// Zero latency; no flow control, o_valid simply reflects any request.
module rr_priority_pick
   import tristate_bus_arbiter_pkg::*;
#(
   parameter int NrOfPorts = 4
)(
   input  logic [NrOfPorts-1:0] i_req,
   input  port_id_t             i_last_id,
   output logic                 o_valid,
   output port_id_t             o_winner_id
);

   logic [2*NrOfPorts-1:0] w_dbl;
   logic [NrOfPorts-1:0]   w_rot;
   logic [3:0]             w_start;
   logic [3:0]             w_sum;
   port_id_t               w_off;

   // Rotating a doubled copy puts the search start at bit 0.
   assign w_start = {1'b0, i_last_id} + 4'd1;
   assign w_dbl   = {i_req, i_req};
   assign w_rot   = NrOfPorts'(w_dbl >> w_start);

   always_comb begin
      w_off = '0;
      for (int j = NrOfPorts - 1; j >= 0; j--) begin
         if (w_rot[j]) w_off = port_id_t'(j);
      end
      w_sum = w_start + {1'b0, w_off};
      if (w_sum >= 4'(NrOfPorts)) w_sum = w_sum - 4'(NrOfPorts);
   end

   assign o_valid     = |i_req;
   assign o_winner_id = w_sum[IdWidth-1:0];

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus with a hold limit and turnaround cycle.
// Grant registered one cycle after request; owners are preempted after MaxHold cycles.
module tristate_bus_arbiter
   import tristate_bus_arbiter_pkg::*;
#(
   parameter int NrOfPorts = 4,
   parameter int MaxHold   = 16
)(
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic [NrOfPorts-1:0] i_req,
   output logic [NrOfPorts-1:0] o_grant,
   output logic [2:0]           o_grant_id,
   output logic                 o_bus_busy,
   output logic                 o_timeout
);

   localparam logic [NrOfPorts-1:0] OneLsb  = NrOfPorts'(1);
   localparam logic [7:0]           HoldMax = 8'(MaxHold);
   localparam port_id_t             LastRst = port_id_t'(NrOfPorts - 1);

   logic [1:0]           r_state;
   logic [NrOfPorts-1:0] r_grant;
   port_id_t             r_grant_id;
   logic                 r_busy;
   logic                 r_timeout;
   logic [7:0]           r_hold_cnt;
   port_id_t             r_last_id;

   logic                 w_pick_vld;
   port_id_t             w_pick_id;
   logic                 w_owner_req;

   rr_priority_pick #(
      .NrOfPorts (NrOfPorts)
   ) u_pick (
      .i_req       (i_req),
      .i_last_id   (r_last_id),
      .o_valid     (w_pick_vld),
      .o_winner_id (w_pick_id)
   );

   // Masking by the one-hot grant avoids a variable-width index into i_req.
   assign w_owner_req = |(i_req & r_grant);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
         r_hold_cnt <= '0;
         r_last_id  <= LastRst;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_GRANT: begin
               if (!w_owner_req || r_hold_cnt == HoldMax) begin
                  r_state    <= ST_TURN;
                  r_grant    <= '0;
                  r_grant_id <= '0;
                  r_busy     <= 1'b0;
                  r_hold_cnt <= '0;
                  r_timeout  <= w_owner_req;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            default: begin
               if (w_pick_vld) begin
                  r_state    <= ST_GRANT;
                  r_grant    <= OneLsb << w_pick_id;
                  r_grant_id <= w_pick_id;
                  r_busy     <= 1'b1;
                  r_hold_cnt <= 8'd1;
                  r_last_id  <= w_pick_id;
               end else begin
                  r_state    <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign o_grant    = r_grant;
   assign o_grant_id = r_grant_id;
   assign o_bus_busy = r_busy;
   assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed scoreboard checks on two arbiter instances (MaxHold 16 and 1) plus a random property run.
module tb_tristate_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req0 = '0;
   logic [3:0] req1 = '0;
   logic [3:0] g0, g1;
   logic [2:0] id0, id1;
   logic       busy0, busy1, to0, to1;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       sel;
      logic [3:0] g;
      logic [2:0] id;
      logic       to;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   tristate_bus_arbiter #(.NrOfPorts(4), .MaxHold(16)) u_dut0 (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_req      (req0),
      .o_grant    (g0),
      .o_grant_id (id0),
      .o_bus_busy (busy0),
      .o_timeout  (to0)
   );

   tristate_bus_arbiter #(.NrOfPorts(4), .MaxHold(1)) u_dut1 (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_req      (req1),
      .o_grant    (g1),
      .o_grant_id (id1),
      .o_bus_busy (busy1),
      .o_timeout  (to1)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of stimulus, queue the expected registered response, compare after the edge.
   task automatic cyc(input string tag, input logic sel, input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [2:0] eid, input logic eto);
      exp_t e;
      rst = r;
      if (sel) req1 = rq;
      else     req0 = rq;
      sb.push_back('{sel: sel, g: eg, id: eid, to: eto});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.sel) begin
         chk({tag, "/grant"},   8'(g1),    8'(e.g));
         chk({tag, "/id"},      8'(id1),   8'(e.id));
         chk({tag, "/busy"},    8'(busy1), 8'(|e.g));
         chk({tag, "/timeout"}, 8'(to1),   8'(e.to));
      end else begin
         chk({tag, "/grant"},   8'(g0),    8'(e.g));
         chk({tag, "/id"},      8'(id0),   8'(e.id));
         chk({tag, "/busy"},    8'(busy0), 8'(|e.g));
         chk({tag, "/timeout"}, 8'(to0),   8'(e.to));
      end
   endtask

   initial begin
      logic [3:0] prev;
      int         run;
      logic       gap_ok;

      // Reset state, including reset winning over active requests
      cyc("rst",     0, 1, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("rst_req", 0, 1, 4'hF, 4'h0, 3'd0, 1'b0);

      // Single requester: grant after one cycle, release gives TURN then IDLE
      for (int i = 0; i < 4; i++) cyc("single", 0, 0, 4'h1, 4'h1, 3'd0, 1'b0);
      cyc("single_turn", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("single_idle", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);

      // 0101: owner 0 releases, port 2 granted straight out of TURN
      cyc("rst", 0, 1, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("p0",  0, 0, 4'h5, 4'h1, 3'd0, 1'b0);
      cyc("p0",  0, 0, 4'h5, 4'h1, 3'd0, 1'b0);
      cyc("p0_turn", 0, 0, 4'h4, 4'h0, 3'd0, 1'b0);
      cyc("p2_direct", 0, 0, 4'h4, 4'h4, 3'd2, 1'b0);
      cyc("p2_turn", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("p2_idle", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);

      // All requesting: 0,1,2,3,0 each for MaxHold cycles, Timeout in every TURN
      cyc("rst", 0, 1, 4'hF, 4'h0, 3'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         for (int h = 0; h < 16; h++)
            cyc("rr_hold", 0, 0, 4'hF, 4'(1 << (k % 4)), 3'(k % 4), 1'b0);
         cyc("rr_turn", 0, 0, 4'hF, 4'h0, 3'd0, 1'b1);
      end
      cyc("rr_idle", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);

      // Owner drops request in the very cycle its hold expires: no Timeout
      cyc("rst", 0, 1, 4'h0, 4'h0, 3'd0, 1'b0);
      for (int h = 0; h < 16; h++) cyc("p2_hold", 0, 0, 4'h4, 4'h4, 3'd2, 1'b0);
      cyc("p2_drop_at_max", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("p2_drop_idle",   0, 0, 4'h0, 4'h0, 3'd0, 1'b0);

      // Non-owner request changes ignored; reset mid-grant clears at once
      cyc("rst", 0, 1, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("p1",  0, 0, 4'h2, 4'h2, 3'd1, 1'b0);
      cyc("p1_others", 0, 0, 4'hB, 4'h2, 3'd1, 1'b0);
      cyc("p1_others", 0, 0, 4'hA, 4'h2, 3'd1, 1'b0);
      cyc("rst_mid",   0, 1, 4'h2, 4'h0, 3'd0, 1'b0);
      cyc("prio_0011", 0, 0, 4'h3, 4'h1, 3'd0, 1'b0);
      cyc("prio_turn", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("p1_again",  0, 0, 4'h2, 4'h2, 3'd1, 1'b0);
      cyc("rst_mid2",  0, 1, 4'h2, 4'h0, 3'd0, 1'b0);
      cyc("prio_0110", 0, 0, 4'h6, 4'h2, 3'd1, 1'b0);
      cyc("prio_turn", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);
      cyc("prio_idle", 0, 0, 4'h0, 4'h0, 3'd0, 1'b0);

      // MaxHold = 1: single-cycle grants alternating with timed-out TURNs
      cyc("rst1", 1, 1, 4'h0, 4'h0, 3'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc("mh1_grant", 1, 0, 4'h3, 4'(1 << (k % 2)), 3'(k % 2), 1'b0);
         cyc("mh1_turn",  1, 0, 4'h3, 4'h0, 3'd0, 1'b1);
      end
      cyc("mh1_idle", 1, 0, 4'h0, 4'h0, 3'd0, 1'b0);

      // Random requests: one-hot, turnaround between owners, hold bound
      prev = '0;
      run  = 0;
      for (int i = 0; i < 10000; i++) begin
         req0 = 4'($urandom) | 4'($urandom);
         @(posedge clk);
         #1;
         chk("rand_onehot", 8'($onehot0(g0)), 8'd1);
         gap_ok = !(g0 != 4'h0 && prev != 4'h0 && g0 != prev);
         chk("rand_gap", 8'(gap_ok), 8'd1);
         if (g0 != 4'h0 && g0 == prev) run = run + 1;
         else                          run = (g0 != 4'h0) ? 1 : 0;
         chk("rand_maxhold", 8'(run <= 16), 8'd1);
         prev = g0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
